// File: rtl/pe_stage_sequencer_if.sv
// pe_stage_sequencer_if: job request, stage control and result bundle around the stage sequencer
interface pe_stage_sequencer_if #(
  parameter int NUM_STAGES = 6,
  parameter int TAG_W = 3,
  parameter int TIMEOUT_W = 16,
  parameter int CYC_W = 16
);
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  logic                  start_valid;
  logic                  start_ready;
  logic [TAG_W-1:0]      start_tag;
  logic [NUM_STAGES-1:0] bypass_mask;
  logic [TIMEOUT_W-1:0]  timeout_limit;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_capture;
  logic                  final_calc;
  logic                  busy;
  logic [STG_W-1:0]      cur_stage;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_error;
  logic [STG_W-1:0]      err_stage;
  logic [CYC_W-1:0]      out_cycles;
  modport master (
    output start_valid, start_tag, bypass_mask, timeout_limit, abort, stage_done, out_ready,
    input  start_ready, stage_start, stage_capture, final_calc, busy, cur_stage,
           out_valid, out_tag, out_error, err_stage, out_cycles
  );
  modport slave (
    input  start_valid, start_tag, bypass_mask, timeout_limit, abort, stage_done, out_ready,
    output start_ready, stage_start, stage_capture, final_calc, busy, cur_stage,
           out_valid, out_tag, out_error, err_stage, out_cycles
  );
endinterface

// File: rtl/pe_stage_sequencer.sv
// pe_stage_sequencer: runs unbypassed sub-stages in index order with start/done handshakes, watchdog and held result
module pe_stage_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int TAG_W = 3,
  parameter int TIMEOUT_W = 16,
  parameter int CYC_W = 16
) (
  input logic clk,
  input logic rst,
  pe_stage_sequencer_if.slave ctl
);
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT, FINAL, OUTPUT} state_t;
  state_t                state_q;
  logic [NUM_STAGES-1:0] mask_q, start_q, cur_oh;
  logic [TAG_W-1:0]      tag_q;
  logic [TIMEOUT_W-1:0]  limit_q, timer_q;
  logic [CYC_W-1:0]      cyc_q, cyc_inc;
  logic [STG_W-1:0]      cur_q, errstg_q, first_idx, nxt_idx;
  logic                  first_ok, nxt_ok, final_q, valid_q, err_q, done_cur, expire;
  assign cur_oh   = NUM_STAGES'(1) << cur_q;
  assign done_cur = |(cur_oh & ctl.stage_done);
  assign expire   = (limit_q != '0) && (timer_q == limit_q - TIMEOUT_W'(1));
  assign cyc_inc  = cyc_q + CYC_W'(cyc_q != '1);
  assign ctl.start_ready   = (state_q == IDLE) && !ctl.abort && !rst;
  assign ctl.stage_capture = (state_q == WAIT) ? (cur_oh & ctl.stage_done) : '0;
  assign ctl.stage_start   = start_q;
  assign ctl.final_calc    = final_q;
  assign ctl.busy          = state_q != IDLE;
  assign ctl.cur_stage     = cur_q;
  assign ctl.out_valid     = valid_q;
  assign ctl.out_tag       = tag_q;
  assign ctl.out_error     = err_q;
  assign ctl.err_stage     = errstg_q;
  assign ctl.out_cycles    = cyc_q;
  // descending scan so the last hit is the lowest qualifying index
  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    nxt_idx   = '0;
    nxt_ok    = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!ctl.bypass_mask[i]) begin
        first_idx = STG_W'(i);
        first_ok  = 1'b1;
      end
      if (!mask_q[i] && i > int'(cur_q)) begin
        nxt_idx = STG_W'(i);
        nxt_ok  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      start_q  <= '0;
      tag_q    <= '0;
      limit_q  <= '0;
      timer_q  <= '0;
      cyc_q    <= '0;
      cur_q    <= '0;
      errstg_q <= '0;
      final_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (ctl.abort && state_q != IDLE) begin
      state_q <= IDLE;
      start_q <= '0;
      final_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      start_q <= '0;
      final_q <= 1'b0;
      case (state_q)
        IDLE: if (ctl.start_valid && ctl.start_ready) begin
          tag_q    <= ctl.start_tag;
          mask_q   <= ctl.bypass_mask;
          limit_q  <= ctl.timeout_limit;
          cyc_q    <= '0;
          err_q    <= 1'b0;
          errstg_q <= '0;
          cur_q    <= first_idx;
          start_q  <= first_ok ? (NUM_STAGES'(1) << first_idx) : '0;
          final_q  <= !first_ok;
          state_q  <= first_ok ? START : FINAL;
        end
        START: begin
          cyc_q   <= cyc_inc;
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cyc_q <= cyc_inc;
          if (done_cur) begin
            cur_q   <= nxt_ok ? nxt_idx : cur_q;
            start_q <= nxt_ok ? (NUM_STAGES'(1) << nxt_idx) : '0;
            final_q <= !nxt_ok;
            state_q <= nxt_ok ? START : FINAL;
          end else if (expire) begin
            err_q    <= 1'b1;
            errstg_q <= cur_q;
            valid_q  <= 1'b1;
            state_q  <= OUTPUT;
          end else begin
            timer_q <= timer_q + TIMEOUT_W'(1);
          end
        end
        FINAL: begin
          cyc_q   <= cyc_inc;
          valid_q <= 1'b1;
          state_q <= OUTPUT;
        end
        OUTPUT: if (ctl.out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
